// File: rtl/hazard_sequencer.sv
// hazard_sequencer: stall, flush, bubble, forwarding, OUT handshake and HALT control for the 4-stage core
module hazard_sequencer #(
  parameter int REG_ADDR_W  = 2,
  parameter int OUT_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [1:0]            id_opcode,
  input  logic [1:0]            id_funct,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  out_ready,
  output logic                  pc_stall,
  output logic                  ifid_stall,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  ex_stall,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  out_valid,
  output logic                  halted,
  output logic                  err_timeout
);
  localparam int CW = OUT_TIMEOUT > 0 ? $clog2(OUT_TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {RUN, OUT_WAIT, HALTED} state_t;
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  is_load;
    logic                  is_out;
    logic                  is_halt;
  } stage_t;
  state_t                state, state_nx;
  stage_t                ex, id_dec;
  logic                  wb_valid, wb_we;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [CW-1:0]         cnt;
  logic                  special, rd_a, rd_b, is_jump;
  logic                  run, waiting, timeout, freeze, load_use;
  assign special = id_opcode == 2'b10;
  assign rd_a    = id_valid && (id_opcode == 2'b01 || special && id_funct != 2'b11);
  assign rd_b    = id_valid && special && id_funct != 2'b11;
  assign is_jump = id_valid && special && id_funct == 2'b11;
  always_comb begin
    id_dec      = '{valid: id_valid, rd: id_rd, we: id_opcode == 2'b00 || special && !id_funct[1],
                    is_load: id_opcode == 2'b00, is_out: id_opcode == 2'b01, is_halt: id_opcode == 2'b11};
    run         = state == RUN;
    waiting     = state == OUT_WAIT;
    halted      = state == HALTED;
    timeout     = OUT_TIMEOUT != 0 && waiting && !out_ready && cnt == CW'(OUT_TIMEOUT);
    out_valid   = waiting || run && ex.valid && ex.is_out;
    freeze      = out_valid && !out_ready && !timeout;
    load_use    = run && !freeze && ex.valid && ex.is_load &&
                  (rd_a && id_rs1 == ex.rd || rd_b && id_rs2 == ex.rd);
    pc_stall    = halted || freeze || load_use;
    ifid_stall  = pc_stall;
    idex_bubble = halted || load_use;
    ex_stall    = freeze;
    ifid_flush  = is_jump && !halted && !freeze && !load_use;
    err_timeout = timeout;
    fwd_a       = !rd_a ? 2'b00 :
                  ex.valid && ex.we && !ex.is_load && ex.rd == id_rs1 ? 2'b01 :
                  wb_valid && wb_we && wb_rd == id_rs1 ? 2'b10 : 2'b00;
    fwd_b       = !rd_b ? 2'b00 :
                  ex.valid && ex.we && !ex.is_load && ex.rd == id_rs2 ? 2'b01 :
                  wb_valid && wb_we && wb_rd == id_rs2 ? 2'b10 : 2'b00;
    state_nx    = halted || run && ex.valid && ex.is_halt ? HALTED : freeze ? OUT_WAIT : RUN;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      ex       <= '0;
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      cnt      <= '0;
    end else begin
      state <= state_nx;
      cnt   <= waiting && freeze ? cnt + 1'b1 : '0;
      if (!ex_stall) begin
        ex       <= idex_bubble ? '0 : id_dec;
        wb_valid <= ex.valid;
        wb_we    <= ex.we;
        wb_rd    <= ex.rd;
      end
    end
  end
endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: directed self-checking bench for hazard_sequencer
module tb_hazard_sequencer;
  localparam logic [1:0] LD = 2'b00, OT = 2'b01, SP = 2'b10, HT = 2'b11;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, CMP = 2'b10, JMP = 2'b11;
  logic       clk = 1'b0, rst_n = 1'b0, id_valid = 1'b0, out_ready = 1'b1;
  logic [1:0] id_opcode = '0, id_funct = '0, id_rd = '0, id_rs1 = '0, id_rs2 = '0;
  logic       pc_stall, ifid_stall, ifid_flush, idex_bubble, ex_stall, out_valid, halted, err_timeout;
  logic [1:0] fwd_a, fwd_b;
  logic [11:0] obs;
  int errors = 0, checks = 0;
  hazard_sequencer #(.REG_ADDR_W(2), .OUT_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .out_ready(out_ready),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .ex_stall(ex_stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .out_valid(out_valid), .halted(halted),
    .err_timeout(err_timeout)
  );
  always #5 clk = ~clk;
  task automatic id(input logic v, input logic [1:0] op, input logic [1:0] fn,
                    input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2);
    id_valid = v; id_opcode = op; id_funct = fn; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // ctrl = {pc_stall, ifid_stall, ifid_flush, idex_bubble, ex_stall, out_valid, halted, err_timeout}
  task automatic chk(input string tag, input logic [7:0] ctrl, input logic [1:0] fa, input logic [1:0] fb);
    #1;
    obs = {pc_stall, ifid_stall, ifid_flush, idex_bubble, ex_stall, out_valid, halted, err_timeout, fwd_a, fwd_b};
    checks++;
    assert (obs === {ctrl, fa, fb})
    else begin
      errors++;
      $error("FAIL %s observed=%03h expected=%03h", tag, obs, {ctrl, fa, fb});
    end
  endtask
  initial begin
    id(0, LD, ADD, 0, 0, 0);
    tick(); tick();
    chk("reset", 8'h00, 2'd0, 2'd0);
    rst_n = 1'b1;
    id(1, LD, ADD, 1, 0, 0);  chk("load_id", 8'h00, 2'd0, 2'd0);   tick();
    id(1, SP, ADD, 2, 1, 3);  chk("load_use", 8'hD0, 2'd0, 2'd0);  tick();
    chk("load_fwd_wb", 8'h00, 2'd2, 2'd0);                         tick();
    id(1, SP, ADD, 1, 0, 0);  chk("add_r1", 8'h00, 2'd0, 2'd0);    tick();
    id(1, SP, SUB, 2, 1, 1);  chk("fwd_ex", 8'h00, 2'd1, 2'd1);    tick();
    id(1, SP, ADD, 1, 0, 0);  chk("add_r1b", 8'h00, 2'd0, 2'd0);   tick();
    id(0, SP, SUB, 2, 1, 1);  chk("idle_fwd", 8'h00, 2'd0, 2'd0);  tick();
    id(1, SP, SUB, 2, 1, 1);  chk("fwd_wb", 8'h00, 2'd2, 2'd2);    tick();
    id(1, SP, ADD, 1, 0, 0);  chk("add_r1c", 8'h00, 2'd0, 2'd0);   tick();
    id(0, LD, ADD, 0, 0, 0);  tick(); tick();
    id(1, SP, SUB, 2, 1, 1);  chk("fwd_none", 8'h00, 2'd0, 2'd0);  tick();
    id(1, SP, ADD, 1, 0, 0);  tick();
    id(1, SP, SUB, 1, 0, 0);  tick();
    id(1, SP, ADD, 3, 1, 1);  chk("fwd_prio", 8'h00, 2'd1, 2'd1);  tick();
    id(1, SP, JMP, 0, 0, 0);  chk("jump", 8'h20, 2'd0, 2'd0);      tick();
    id(0, LD, ADD, 0, 0, 0);  chk("jump_once", 8'h00, 2'd0, 2'd0); tick();
    id(1, LD, ADD, 2, 0, 0);  tick();
    id(1, SP, ADD, 0, 2, 1);  chk("lu_stall", 8'hD0, 2'd0, 2'd0);  tick();
    chk("lu_after", 8'h00, 2'd2, 2'd0);                            tick();
    id(1, SP, JMP, 0, 0, 0);  chk("lu_jump", 8'h20, 2'd0, 2'd0);   tick();
    id(1, SP, CMP, 1, 2, 3);  chk("cmp", 8'h00, 2'd0, 2'd0);       tick();
    id(1, SP, ADD, 0, 1, 1);  chk("cmp_nowr", 8'h00, 2'd0, 2'd0);  tick();
    out_ready = 1'b0;
    id(1, OT, ADD, 0, 2, 0);  chk("out_id", 8'h00, 2'd0, 2'd0);    tick();
    id(1, SP, JMP, 0, 0, 0);  chk("out_c1", 8'hCC, 2'd0, 2'd0);    tick();
    chk("out_c2", 8'hCC, 2'd0, 2'd0);                              tick();
    chk("out_c3", 8'hCC, 2'd0, 2'd0);                              tick();
    out_ready = 1'b1;
    chk("out_c4", 8'h24, 2'd0, 2'd0);                              tick();
    id(0, LD, ADD, 0, 0, 0);  chk("out_done", 8'h00, 2'd0, 2'd0);  tick();
    out_ready = 1'b0;
    id(1, OT, ADD, 0, 1, 0);  tick();
    id(0, LD, ADD, 0, 0, 0);  chk("to_c1", 8'hCC, 2'd0, 2'd0);     tick();
    for (int i = 0; i < 4; i++) begin
      chk("to_wait", 8'hCC, 2'd0, 2'd0);
      tick();
    end
    chk("to_pulse", 8'h05, 2'd0, 2'd0);                            tick();
    id(1, HT, ADD, 0, 0, 0);  chk("to_after", 8'h00, 2'd0, 2'd0);  tick();
    out_ready = 1'b1;
    id(1, SP, ADD, 1, 0, 0);  chk("halt_ex", 8'h00, 2'd0, 2'd0);   tick();
    id(1, SP, JMP, 0, 0, 0);  chk("halted", 8'hD2, 2'd0, 2'd0);    tick();
    id(1, SP, SUB, 2, 0, 0);  chk("halted_hold", 8'hD2, 2'd0, 2'd0); tick();
    rst_n = 1'b0;
    chk("halt_rst_pend", 8'hD2, 2'd0, 2'd0);                       tick();
    rst_n = 1'b1;
    id(0, LD, ADD, 0, 0, 0);  chk("halt_rst", 8'h00, 2'd0, 2'd0);
    out_ready = 1'b0;
    id(1, OT, ADD, 0, 3, 0);  tick();
    id(0, LD, ADD, 0, 0, 0);  chk("rw_c1", 8'hCC, 2'd0, 2'd0);     tick();
    rst_n = 1'b0;
    chk("rw_pend", 8'hCC, 2'd0, 2'd0);                             tick();
    chk("rw_reset", 8'h00, 2'd0, 2'd0);
    rst_n = 1'b1;                                                  tick();
    chk("rw_discard", 8'h00, 2'd0, 2'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
